// File: rtl/sd_spi_card_model_if.sv
// sd_spi_card_model_if: SPI pins plus decoded-command status between an SD host and the card model
// Signals: SD_cs, SD_datain (host -> card); SD_dataout, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready (card -> host)
// Modports: master (host side), slave (card side)
interface sd_spi_card_model_if;
  logic SD_cs, SD_datain, SD_dataout, cmd_valid, card_idle, card_ready;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  modport master(output SD_cs, SD_datain, input SD_dataout, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready);
  modport slave(input SD_cs, SD_datain, output SD_dataout, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready);
endinterface

// File: rtl/sd_spi_card_model.sv
// sd_spi_card_model: SPI-mode SD card responder answering CMD0, CMD8, CMD55/ACMD41 with R1/R7
// Ports: SD_clk (SPI clock; MOSI sampled on posedge, MISO driven on negedge), rst_n (async, active-low),
//        bus (slave modport: SD_cs/SD_datain in; SD_dataout, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready out)
module sd_spi_card_model #(
  parameter int NCR_BITS = 8,
  parameter int ACMD41_BUSY = 3,
  parameter bit CHECK_CRC = 1'b1
) (
  input logic SD_clk,
  input logic rst_n,
  sd_spi_card_model_if.slave bus
);
  typedef enum logic [1:0] {RX_IDLE, RX_CMD, NCR_WAIT, TX_RESP} state_t;
  localparam logic [6:0] NCR = 7'(NCR_BITS);
  localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY);
  state_t state, state_n;
  logic [6:0] cnt, crc;
  logic [44:0] sr;
  logic [39:0] resp, resp_n;
  logic [7:0] busy_cnt, r1;
  logic [5:0] cmd_index, idx;
  logic [31:0] cmd_arg, arg;
  logic [3:0] vhs;
  logic prev, is_r7, spi_mode, app_pending, dout, cmd_valid, card_idle, card_ready;
  logic cs, din, fb, at_end, respond, crc_bad, acmd, acmd_busy;
  assign cs = bus.SD_cs;
  assign din = bus.SD_datain;
  // sr holds frame bits 2..46 once the end bit is being sampled
  assign idx = sr[44:39];
  assign arg = sr[38:7];
  assign fb = din ^ crc[6];
  assign at_end = state == RX_CMD && cnt == 7'd47;
  assign respond = spi_mode || idx == 6'd0;
  assign crc_bad = CHECK_CRC && (idx == 6'd0 || idx == 6'd8) && crc != sr[6:0];
  assign acmd = idx == 6'd41 && app_pending;
  assign acmd_busy = busy_cnt < BUSY_MAX;
  assign vhs = arg[11:8] == 4'b0001 ? 4'b0001 : 4'b0000;
  assign r1 = idx == 6'd0 ? {4'b0, crc_bad, 3'b001} :
      idx == 6'd8 ? {4'b0, crc_bad, 2'b0, card_idle} :
      idx == 6'd55 ? {7'b0, card_idle} :
      acmd ? {7'b0, acmd_busy} : {5'b0, 1'b1, 1'b0, card_idle};
  // responses are left-aligned so TX_RESP always shifts out of bit 39
  assign resp_n = idx == 6'd8 ? {r1, 20'h0, vhs, arg[7:0]} : {r1, 32'h0};
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:  state_n = !prev && din ? RX_CMD : RX_IDLE;
      RX_CMD:   state_n = cnt != 7'd47 ? RX_CMD : respond ? NCR_WAIT : RX_IDLE;
      NCR_WAIT: state_n = cnt == 7'd1 ? TX_RESP : NCR_WAIT;
      default:  state_n = cnt == 7'd1 ? RX_IDLE : TX_RESP;
    endcase
    if (cs) state_n = RX_IDLE;
  end
  always_ff @(posedge SD_clk or negedge rst_n)
    if (!rst_n) state <= RX_IDLE;
    else state <= state_n;
  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      crc <= '0;
      sr <= '0;
      resp <= '0;
      is_r7 <= 1'b0;
      prev <= 1'b1;
      busy_cnt <= '0;
      spi_mode <= 1'b0;
      app_pending <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg <= '0;
      card_idle <= 1'b1;
      card_ready <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      prev <= state == RX_IDLE && !cs ? din : 1'b1;
      if (!cs) begin
        case (state)
          RX_IDLE: begin
            // CRC7 after the fixed start bits 0,1 is 7'h09
            cnt <= 7'd2;
            crc <= 7'h09;
          end
          RX_CMD: begin
            sr <= {sr[43:0], din};
            cnt <= at_end ? NCR : cnt + 7'd1;
            if (cnt < 7'd40) crc <= {crc[5:0], 1'b0} ^ {3'b0, fb, 2'b0, fb};
            if (at_end) begin
              cmd_valid <= 1'b1;
              cmd_index <= idx;
              cmd_arg <= arg;
              resp <= resp_n;
              is_r7 <= idx == 6'd8;
              app_pending <= spi_mode && idx == 6'd55;
              if (idx == 6'd0) begin
                spi_mode <= 1'b1;
                card_idle <= 1'b1;
                card_ready <= 1'b0;
                busy_cnt <= '0;
              end
              if (acmd && spi_mode) begin
                if (acmd_busy) busy_cnt <= busy_cnt + 8'd1;
                else begin
                  card_idle <= 1'b0;
                  card_ready <= 1'b1;
                end
              end
            end
          end
          NCR_WAIT: cnt <= cnt == 7'd1 ? (is_r7 ? 7'd40 : 7'd8) : cnt - 7'd1;
          default: begin
            resp <= {resp[38:0], 1'b0};
            cnt <= cnt - 7'd1;
          end
        endcase
      end
    end
  end
  // MISO launches on negedge; chip-select high forces it idle before the next host sample
  always_ff @(negedge SD_clk or negedge rst_n)
    if (!rst_n) dout <= 1'b1;
    else dout <= cs || state != TX_RESP || resp[39];
  assign bus.SD_dataout = dout;
  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_index = cmd_index;
  assign bus.cmd_arg = cmd_arg;
  assign bus.card_idle = card_idle;
  assign bus.card_ready = card_ready;
endmodule

// File: tb/tb_sd_spi_card_model.sv
// tb_sd_spi_card_model: scoreboard bench driving SD host init frames into the SPI card model
module tb_sd_spi_card_model;
  localparam int NCR = 8;
  typedef struct { logic [47:0] val; int start; } resp_t;
  typedef struct { logic [5:0] idx; logic [31:0] arg; } cmd_t;
  logic SD_clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0, bad = 0, cyc = 0, cap_left = 0;
  bit mon_en = 1'b1;
  logic [47:0] cap = '0;
  resp_t exp_q[$];
  resp_t cur;
  cmd_t cmd_q[$];
  cmd_t cc;
  sd_spi_card_model_if bus();
  sd_spi_card_model #(.NCR_BITS(NCR), .ACMD41_BUSY(3), .CHECK_CRC(1'b1)) dut (
    .SD_clk(SD_clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 SD_clk = ~SD_clk;
  always @(posedge SD_clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  // response monitor: host-side 48-bit capture starting at the first 0 on MISO
  always @(posedge SD_clk) begin
    #1;
    if (mon_en && cap_left == 0 && bus.SD_dataout === 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_resp", 48'(bus.SD_dataout), 48'd1);
      else begin
        cur = exp_q.pop_front();
        check("ncr_start_cycle", 48'(cyc), 48'(cur.start));
        cap_left = 48;
      end
    end
    if (mon_en && cap_left > 0) begin
      cap = {cap[46:0], bus.SD_dataout};
      cap_left--;
      if (cap_left == 0) check("resp_capture", cap, cur.val);
    end
  end
  always @(negedge SD_clk)
    if (bus.cmd_valid === 1'b1) begin
      if (cmd_q.size() == 0) check("unexpected_cmd_valid", 48'(bus.cmd_valid), 48'd0);
      else begin
        cc = cmd_q.pop_front();
        check("cmd_decode", {10'd0, bus.cmd_index, bus.cmd_arg}, {10'd0, cc.idx, cc.arg});
      end
    end
  task automatic quiet(input string name, input int n);
    int zeros = 0;
    repeat (n) begin
      @(posedge SD_clk);
      #1;
      if (bus.SD_dataout !== 1'b1) zeros++;
    end
    check(name, 48'(zeros), 48'd0);
  endtask
  // mode 0: expect response r (len bits), 1: expect silence, 2: send only
  task automatic send(input logic [47:0] f, input int mode, input int len, input logic [39:0] r);
    resp_t e;
    cmd_t c;
    int n = 0;
    for (int i = 47; i >= 0; i--) begin
      @(negedge SD_clk);
      bus.SD_datain = f[i];
      if (i == 0) begin
        c.idx = f[45:40];
        c.arg = f[39:8];
        cmd_q.push_back(c);
        if (mode == 0) begin
          e.val = len == 8 ? {r[39:32], 40'hFF_FFFF_FFFF} : {r, 8'hFF};
          e.start = cyc + NCR + 2;
          exp_q.push_back(e);
        end
      end
    end
    @(negedge SD_clk);
    bus.SD_datain = 1'b1;
    if (mode == 0) begin
      while (n < 300 && (exp_q.size() != 0 || cap_left != 0)) begin
        @(negedge SD_clk);
        n++;
      end
      check("resp_wait", 48'(exp_q.size() + cap_left), 48'd0);
    end
    if (mode == 1) quiet("no_resp", 64);
    repeat (4) @(negedge SD_clk);
  endtask
  localparam logic [47:0] CMD0 = 48'h40_00_00_00_00_95;
  localparam logic [47:0] CMD8 = 48'h48_00_00_01_AA_87;
  localparam logic [47:0] CMD55 = 48'h77_00_00_00_00_FF;
  localparam logic [47:0] CMD41 = 48'h69_40_00_00_00_FF;
  initial begin
    logic [47:0] f;
    int n = 0;
    bus.SD_cs = 1'b1;
    bus.SD_datain = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge SD_clk);
    check("rst_dataout", 48'(bus.SD_dataout), 48'd1);
    check("rst_cmd_valid", 48'(bus.cmd_valid), 48'd0);
    check("rst_cmd_index", 48'(bus.cmd_index), 48'd0);
    check("rst_cmd_arg", 48'(bus.cmd_arg), 48'd0);
    check("rst_card_idle", 48'(bus.card_idle), 48'd1);
    check("rst_card_ready", 48'(bus.card_ready), 48'd0);
    rst_n = 1'b1;
    @(negedge SD_clk);
    bus.SD_cs = 1'b0;
    repeat (4) @(negedge SD_clk);
    send(CMD8, 1, 0, 40'h0);
    send(CMD0, 0, 8, 40'h01_0000_0000);
    send(CMD8, 0, 40, 40'h01_00_00_01_AA);
    send(CMD41, 0, 8, 40'h05_0000_0000);
    send(48'h40_00_00_00_00_97, 0, 8, 40'h09_0000_0000);
    check("badcrc_card_idle", 48'(bus.card_idle), 48'd1);
    f = CMD8;
    for (int i = 47; i >= 28; i--) begin
      @(negedge SD_clk);
      bus.SD_datain = f[i];
    end
    @(negedge SD_clk);
    bus.SD_cs = 1'b1;
    bus.SD_datain = 1'b1;
    quiet("abort_silence", 40);
    @(negedge SD_clk);
    bus.SD_cs = 1'b0;
    repeat (2) @(negedge SD_clk);
    send(CMD0, 0, 8, 40'h01_0000_0000);
    for (int k = 0; k < 4; k++) begin
      send(CMD55, 0, 8, 40'h01_0000_0000);
      send(CMD41, 0, 8, k == 3 ? 40'h00_0000_0000 : 40'h01_0000_0000);
      check("card_ready_loop", 48'(bus.card_ready), 48'(k == 3));
    end
    check("ready_card_idle", 48'(bus.card_idle), 48'd0);
    send(CMD55, 0, 8, 40'h00_0000_0000);
    send(CMD41, 0, 8, 40'h00_0000_0000);
    check("ready_sticky", 48'(bus.card_ready), 48'd1);
    mon_en = 1'b0;
    send(CMD8, 2, 0, 40'h0);
    while (n < 100 && bus.SD_dataout !== 1'b0) begin
      @(posedge SD_clk);
      #1;
      n++;
    end
    check("r7_started", 48'(bus.SD_dataout), 48'd0);
    repeat (10) @(posedge SD_clk);
    #3;
    check("pre_rst_miso", 48'(bus.SD_dataout), 48'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_dataout", 48'(bus.SD_dataout), 48'd1);
    check("midrst_card_idle", 48'(bus.card_idle), 48'd1);
    check("midrst_card_ready", 48'(bus.card_ready), 48'd0);
    check("midrst_cmd_index", 48'(bus.cmd_index), 48'd0);
    @(negedge SD_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge SD_clk);
    mon_en = 1'b1;
    send(CMD55, 1, 0, 40'h0);
    check("exp_q_drained", 48'(exp_q.size()), 48'd0);
    check("cmd_q_drained", 48'(cmd_q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
